// File: rtl/tone_phase_accumulator_pkg.sv
// Shared definitions for the tiny-synth tone path: default widths, the
// glide FSM state encoding and the glide direction type.
package tone_phase_accumulator_pkg;

    // Default datapath widths used by every tone-path module.
    localparam int DEFAULT_ACCUMULATOR_BITS = 24;
    localparam int DEFAULT_FREQ_BITS        = 16;
    localparam int GLIDE_RATE_BITS          = 8;

    // Glide controller states. IDLE means freq_current already equals the
    // captured target; the other two say which way the increment is moving.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GLIDE_UP   = 2'd1,
        GLIDE_DOWN = 2'd2
    } glide_state_e;

    // Direction handed to the step-toward-target arithmetic.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } glide_dir_e;

    // Map a glide state onto the direction the stepper should move in.
    // IDLE maps to DIR_UP; the stepper output is ignored while idle.
    function automatic glide_dir_e state_to_dir(input glide_state_e state);
        return (state == GLIDE_DOWN) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage : tone_phase_accumulator_pkg

// File: rtl/glide_stepper.sv
// Combinational one-step move of a frequency word toward its target by a
// fixed rate, clamped so the result never passes the target and never
// wraps around the FREQ_BITS range.
module glide_stepper
    import tone_phase_accumulator_pkg::*;
#(
    parameter int FREQ_BITS = DEFAULT_FREQ_BITS
) (
    input  logic [FREQ_BITS-1:0]       current,
    input  logic [FREQ_BITS-1:0]       target,
    input  logic [GLIDE_RATE_BITS-1:0] rate,
    input  glide_dir_e                 direction,
    output logic [FREQ_BITS-1:0]       next_value
);

    logic [FREQ_BITS-1:0] rate_ext;
    logic [FREQ_BITS-1:0] gap;
    logic                 at_or_past;
    logic                 reaches;

    // Distance to the target in the travel direction; if the step covers
    // that distance (or we are already there) land exactly on the target.
    // Because a non-clamped step is strictly smaller than the gap, the
    // add/subtract below can never overflow or underflow.
    always_comb begin
        rate_ext = FREQ_BITS'(rate);
        if (direction == DIR_UP) begin
            at_or_past = (current >= target);
            gap        = target - current;
        end else begin
            at_or_past = (current <= target);
            gap        = current - target;
        end

        // A zero rate mid-glide is treated like a zero rate at load time:
        // jump straight to the target rather than stalling forever.
        reaches = at_or_past || (rate == '0) || (rate_ext >= gap);

        if (reaches) begin
            next_value = target;
        end else if (direction == DIR_UP) begin
            next_value = current + rate_ext;
        end else begin
            next_value = current - rate_ext;
        end
    end

endmodule : glide_stepper

// File: rtl/tone_phase_accumulator.sv
// Phase accumulator for one oscillator voice. Adds the active frequency
// word to the phase on every sample tick, supports hard sync, and glides
// the active frequency toward a newly loaded target at a programmable rate.
module tone_phase_accumulator
    import tone_phase_accumulator_pkg::*;
#(
    parameter int ACCUMULATOR_BITS = DEFAULT_ACCUMULATOR_BITS,
    parameter int FREQ_BITS        = DEFAULT_FREQ_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_tick,
    input  logic [FREQ_BITS-1:0]        freq_target,
    input  logic                        freq_load,
    input  logic [GLIDE_RATE_BITS-1:0]  glide_rate,
    input  logic                        sync_in,
    output logic [ACCUMULATOR_BITS-1:0] accumulator,
    output logic [FREQ_BITS-1:0]        freq_current,
    output logic                        gliding,
    output logic                        wrap
);

    // FREQ_BITS must be narrower than ACCUMULATOR_BITS; the increment is
    // zero-extended into the accumulator width below.
    localparam int PAD_BITS = ACCUMULATOR_BITS + 1 - FREQ_BITS;

    // Phase path state
    logic [ACCUMULATOR_BITS-1:0] acc_q, acc_d;
    logic                        wrap_q, wrap_d;
    logic                        sync_pending_q, sync_pending_d;

    // Frequency / glide path state
    logic [FREQ_BITS-1:0]        freq_current_q, freq_current_d;
    logic [FREQ_BITS-1:0]        target_q, target_d;
    glide_state_e                state_q, state_d;
    logic                        gliding_q, gliding_d;

    // Datapath helpers
    logic [ACCUMULATOR_BITS:0]   phase_sum;
    logic [FREQ_BITS-1:0]        step_next;
    glide_dir_e                  step_dir;
    logic                        sync_now;

    // Clamped step toward the captured target in the current direction.
    assign step_dir = state_to_dir(state_q);

    glide_stepper #(
        .FREQ_BITS (FREQ_BITS)
    ) u_glide_stepper (
        .current    (freq_current_q),
        .target     (target_q),
        .rate       (glide_rate),
        .direction  (step_dir),
        .next_value (step_next)
    );

    // Phase update: add the pre-step increment on a tick, or zero the phase
    // if a sync is pending or arriving in the same cycle as the tick.
    always_comb begin
        phase_sum      = {1'b0, acc_q} + {{PAD_BITS{1'b0}}, freq_current_q};
        sync_now       = sync_pending_q | sync_in;
        acc_d          = acc_q;
        wrap_d         = 1'b0;
        sync_pending_d = sync_now;

        if (sample_tick) begin
            if (sync_now) begin
                acc_d          = '0;
                sync_pending_d = 1'b0;
            end else begin
                acc_d  = phase_sum[ACCUMULATOR_BITS-1:0];
                wrap_d = phase_sum[ACCUMULATOR_BITS];
            end
        end
    end

    // Glide control: a load captures the target and picks a direction from
    // the present frequency; a tick while gliding takes one clamped step.
    // A load always wins over a step, so the first step of a new glide
    // happens on the tick after the load.
    always_comb begin
        freq_current_d = freq_current_q;
        target_d       = target_q;
        state_d        = state_q;

        if (freq_load) begin
            target_d = freq_target;
            if (glide_rate == '0) begin
                freq_current_d = freq_target;
                state_d        = IDLE;
            end else if (freq_target > freq_current_q) begin
                state_d = GLIDE_UP;
            end else if (freq_target < freq_current_q) begin
                state_d = GLIDE_DOWN;
            end else begin
                state_d = IDLE;
            end
        end else if (sample_tick && (state_q != IDLE)) begin
            freq_current_d = step_next;
            if (step_next == target_q) begin
                state_d = IDLE;
            end
        end

        gliding_d = (state_d != IDLE);
    end

    // Phase path registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= '0;
            wrap_q         <= 1'b0;
            sync_pending_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            wrap_q         <= wrap_d;
            sync_pending_q <= sync_pending_d;
        end
    end

    // Glide FSM and its registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_current_q <= '0;
            target_q       <= '0;
            state_q        <= IDLE;
            gliding_q      <= 1'b0;
        end else begin
            freq_current_q <= freq_current_d;
            target_q       <= target_d;
            state_q        <= state_d;
            gliding_q      <= gliding_d;
        end
    end

    assign accumulator  = acc_q;
    assign freq_current = freq_current_q;
    assign gliding      = gliding_q;
    assign wrap         = wrap_q;

endmodule : tone_phase_accumulator

// File: tb/tb_tone_phase_accumulator.sv
// Self-checking bench for tone_phase_accumulator (24-bit phase, 16-bit
// frequency). Expected results are queued as stimulus is applied and
// popped for comparison one cycle later when the DUT output is visible.
module tb_tone_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic [15:0] freq_target;
    logic        freq_load;
    logic [7:0]  glide_rate;
    logic        sync_in;
    logic [23:0] accumulator;
    logic [15:0] freq_current;
    logic        gliding;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [23:0] acc;
        logic        wrap;
        logic [15:0] freq;
        logic        glide;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        tk;
        logic        ld;
        logic [15:0] tgt;
        logic [7:0]  rate;
        logic        sy;
        exp_t        exp;
    } row_t;

    exp_t        exp_q[$];
    logic [23:0] model_acc;

    tone_phase_accumulator #(
        .ACCUMULATOR_BITS (24),
        .FREQ_BITS        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .freq_target  (freq_target),
        .freq_load    (freq_load),
        .glide_rate   (glide_rate),
        .sync_in      (sync_in),
        .accumulator  (accumulator),
        .freq_current (freq_current),
        .gliding      (gliding),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic rst, input logic tk, input logic ld,
                                input logic [15:0] tgt, input logic [7:0] rate,
                                input logic sy, input logic [23:0] acc,
                                input logic wr, input logic [15:0] fq,
                                input logic gl);
        row_t r;
        r.rst = rst; r.tk = tk; r.ld = ld; r.tgt = tgt; r.rate = rate; r.sy = sy;
        r.exp = '{acc: acc, wrap: wr, freq: fq, glide: gl};
        return r;
    endfunction

    // Drive one cycle of stimulus; outputs are stable #1 after the edge.
    task automatic apply(input logic rst, input logic tk, input logic ld,
                         input logic [15:0] tgt, input logic [7:0] rate, input logic sy);
        rst_n       = rst;
        sample_tick = tk;
        freq_load   = ld;
        freq_target = tgt;
        glide_rate  = rate;
        sync_in     = sy;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        sample_tick = 1'b0;
        freq_load   = 1'b0;
        sync_in     = 1'b0;
    endtask

    task automatic reset_dut();
        apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        exp_q.delete();
        model_acc = 24'h0;
    endtask

    // Reset must win over tick, load and sync all asserted together.
    task automatic test_reset();
        row_t rows[$];
        exp_t e, got;
        rows.push_back(mk(0, 1, 1, 16'hFFFF, 8'h00, 1, 24'h0, 0, 16'h0, 0));
        rows.push_back(mk(0, 1, 1, 16'h1234, 8'h05, 1, 24'h0, 0, 16'h0, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].exp);
            apply(rows[i].rst, rows[i].tk, rows[i].ld, rows[i].tgt, rows[i].rate, rows[i].sy);
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("reset[%0d]: acc=%h wrap=%b freq=%h gliding=%b", i, got.acc, got.wrap, got.freq, got.glide);
        end
    endtask

    // Immediate load (rate 0) then four ticks of 0x1000.
    task automatic test_jump();
        exp_t e, got;
        reset_dut();
        exp_q.push_back('{acc: 24'h0, wrap: 1'b0, freq: 16'h1000, glide: 1'b0});
        apply(1, 0, 1, 16'h1000, 8'h00, 0);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                model_acc = model_acc + 24'h001000;
                exp_q.push_back('{acc: model_acc, wrap: 1'b0, freq: 16'h1000, glide: 1'b0});
                apply(1, 1, 0, 16'h0, 8'h00, 0);
            end
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jump[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("jump[%0d]: acc=%h wrap=%b freq=%h", i, got.acc, got.wrap, got.freq);
        end
        checks++;
        if (accumulator !== 24'h004000) begin
            errors++;
            $display("FAIL jump_final: got acc=%h, expected acc=004000", accumulator);
        end
    endtask

    // 512 ticks of 0x8000 wrap exactly once back to zero, then hold.
    task automatic test_wrap();
        exp_t        e, got;
        logic [24:0] sum;
        int          wrap_count;
        wrap_count = 0;
        reset_dut();
        apply(1, 0, 1, 16'h8000, 8'h00, 0);
        for (int k = 1; k <= 612; k++) begin
            if (k <= 512) begin
                sum       = {1'b0, model_acc} + 25'h0008000;
                model_acc = sum[23:0];
                exp_q.push_back('{acc: model_acc, wrap: sum[24], freq: 16'h8000, glide: 1'b0});
                apply(1, 1, 0, 16'h0, 8'h00, 0);
            end else begin
                exp_q.push_back('{acc: model_acc, wrap: 1'b0, freq: 16'h8000, glide: 1'b0});
                apply(1, 0, 0, 16'h0, 8'h00, 0);
            end
            if (wrap === 1'b1) wrap_count++;
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         k, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            if (k == 512) begin
                checks++;
                if (accumulator !== 24'h000000) begin
                    errors++;
                    $display("FAIL wrap_final: got acc=%h, expected acc=000000", accumulator);
                end
            end
        end
        $display("wrap: 512 ticks + 100 idle cycles, acc=%h, wrap pulses=%0d", accumulator, wrap_count);
        checks++;
        if (wrap_count != 1) begin
            errors++;
            $display("FAIL wrap_count: got %0d pulses, expected 1", wrap_count);
        end
    endtask

    // Hard sync between ticks and in the same cycle as a tick.
    task automatic test_sync();
        row_t rows[$];
        exp_t e, got;
        reset_dut();
        rows.push_back(mk(1, 0, 1, 16'h4000, 8'h00, 0, 24'h000000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h004000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h008000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h00C000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 24'h00C000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 24'h00C000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h000000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h004000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 1, 24'h000000, 0, 16'h4000, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h004000, 0, 16'h4000, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].exp);
            apply(rows[i].rst, rows[i].tk, rows[i].ld, rows[i].tgt, rows[i].rate, rows[i].sy);
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sync[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("sync[%0d]: tick=%b sync=%b acc=%h wrap=%b", i, rows[i].tk, rows[i].sy, got.acc, got.wrap);
        end
    endtask

    // Glide up 0x0100 -> 0x0110 and down 0x0100 -> 0x00F0 at rate 5.
    task automatic test_glide();
        row_t rows[$];
        exp_t e, got;
        reset_dut();
        rows.push_back(mk(1, 0, 1, 16'h0100, 8'h00, 0, 24'h000000, 0, 16'h0100, 0));
        rows.push_back(mk(1, 0, 1, 16'h0110, 8'h05, 0, 24'h000000, 0, 16'h0100, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h000100, 0, 16'h0105, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h000205, 0, 16'h010A, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h00030F, 0, 16'h010F, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h00041E, 0, 16'h0110, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h00052E, 0, 16'h0110, 0));
        rows.push_back(mk(1, 0, 1, 16'h0100, 8'h00, 0, 24'h00052E, 0, 16'h0100, 0));
        rows.push_back(mk(1, 0, 1, 16'h00F0, 8'h05, 0, 24'h00052E, 0, 16'h0100, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h00062E, 0, 16'h00FB, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h000729, 0, 16'h00F6, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h00081F, 0, 16'h00F1, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h05, 0, 24'h000910, 0, 16'h00F0, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].exp);
            apply(rows[i].rst, rows[i].tk, rows[i].ld, rows[i].tgt, rows[i].rate, rows[i].sy);
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL glide[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("glide[%0d]: acc=%h freq=%h gliding=%b", i, got.acc, got.freq, got.glide);
        end
    endtask

    // Load coinciding with a tick, mid-glide retarget, clamping at both
    // ends of the range, and an equal-target load.
    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e, got;
        reset_dut();
        rows.push_back(mk(1, 0, 1, 16'h0200, 8'h00, 0, 24'h000000, 0, 16'h0200, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h000200, 0, 16'h0200, 0));
        rows.push_back(mk(1, 1, 1, 16'h0300, 8'h04, 0, 24'h000400, 0, 16'h0200, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h04, 0, 24'h000600, 0, 16'h0204, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h04, 0, 24'h000804, 0, 16'h0208, 1));
        rows.push_back(mk(1, 0, 1, 16'h0100, 8'h04, 0, 24'h000804, 0, 16'h0208, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h04, 0, 24'h000A0C, 0, 16'h0204, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h04, 0, 24'h000C10, 0, 16'h0200, 1));
        rows.push_back(mk(1, 0, 1, 16'h0100, 8'h80, 0, 24'h000C10, 0, 16'h0200, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h80, 0, 24'h000E10, 0, 16'h0180, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h80, 0, 24'h000F90, 0, 16'h0100, 0));
        rows.push_back(mk(1, 0, 1, 16'h0005, 8'hFF, 0, 24'h000F90, 0, 16'h0100, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'hFF, 0, 24'h001090, 0, 16'h0005, 0));
        rows.push_back(mk(1, 0, 1, 16'hFFFA, 8'h00, 0, 24'h001090, 0, 16'hFFFA, 0));
        rows.push_back(mk(1, 0, 1, 16'hFFFF, 8'hFF, 0, 24'h001090, 0, 16'hFFFA, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'hFF, 0, 24'h01108A, 0, 16'hFFFF, 0));
        rows.push_back(mk(1, 0, 1, 16'hFFFF, 8'h03, 0, 24'h01108A, 0, 16'hFFFF, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h03, 0, 24'h021089, 0, 16'hFFFF, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].exp);
            apply(rows[i].rst, rows[i].tk, rows[i].ld, rows[i].tgt, rows[i].rate, rows[i].sy);
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("b2b[%0d]: tick=%b load=%b acc=%h freq=%h gliding=%b",
                     i, rows[i].tk, rows[i].ld, got.acc, got.freq, got.glide);
        end
    endtask

    // One-cycle reset mid-glide with tick, load and a pending sync; the
    // pending sync must not survive the reset.
    task automatic test_reset_mid_glide();
        row_t rows[$];
        exp_t e, got;
        reset_dut();
        rows.push_back(mk(1, 0, 1, 16'h0100, 8'h00, 0, 24'h000000, 0, 16'h0100, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h000100, 0, 16'h0100, 0));
        rows.push_back(mk(1, 0, 1, 16'h0200, 8'h01, 0, 24'h000100, 0, 16'h0100, 1));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h01, 0, 24'h000200, 0, 16'h0101, 1));
        rows.push_back(mk(1, 0, 0, 16'h0000, 8'h01, 1, 24'h000200, 0, 16'h0101, 1));
        rows.push_back(mk(0, 1, 1, 16'h1234, 8'h00, 1, 24'h000000, 0, 16'h0000, 0));
        rows.push_back(mk(1, 0, 1, 16'h0040, 8'h00, 0, 24'h000000, 0, 16'h0040, 0));
        rows.push_back(mk(1, 1, 0, 16'h0000, 8'h00, 0, 24'h000040, 0, 16'h0040, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].exp);
            apply(rows[i].rst, rows[i].tk, rows[i].ld, rows[i].tgt, rows[i].rate, rows[i].sy);
            e   = exp_q.pop_front();
            got = '{acc: accumulator, wrap: wrap, freq: freq_current, glide: gliding};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rst_glide[%0d]: got acc=%h wrap=%b freq=%h gliding=%b, expected acc=%h wrap=%b freq=%h gliding=%b",
                         i, got.acc, got.wrap, got.freq, got.glide, e.acc, e.wrap, e.freq, e.glide);
            end
            $display("rst_glide[%0d]: rst_n=%b acc=%h freq=%h gliding=%b",
                     i, rows[i].rst, got.acc, got.freq, got.glide);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        freq_target = 16'h0;
        freq_load   = 1'b0;
        glide_rate  = 8'h0;
        sync_in     = 1'b0;
        model_acc   = 24'h0;
        #2;
        test_reset();
        test_jump();
        test_wrap();
        test_sync();
        test_glide();
        test_back_to_back();
        test_reset_mid_glide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tone_phase_accumulator
